ej32_dstack: RTL and testbench
==============================

// Module: ej32_dstack
// PURPOSE
//  eJ32 data-stack unit: slave side of the ss_io stack port, driven by the
//  core's stack-op stage. Holds NOS (the core keeps TOS on its bus) in a cached
//  register, with deeper entries in a register-file array.
//  Services PUSH/POP/PICK in one cycle; flags full/empty and records sticky
//  overflow/underflow errors for debug.
// PARAMETERS
//  DEPTH  64  total entries incl. cached s (>=2); array holds DEPTH-1
//  DSZ    32  data width (matches `DU)
//  CW     $clog2(DEPTH+1)  localparam, width of cnt
// PORTS
//  clk      in   1      core clock; all state updates on posedge
//  rst      in   1      synchronous reset, active-low (sampled on posedge clk)
//  op       in   2      stack_op: NOP=00 PUSH=01 PICK=10 POP=11
//  vi       in   DSZ    value for PUSH
//  pidx     in   CW-1   PICK depth; 0 = s, 1 = entry below s, ...
//  clr_err  in   1      clear sticky ovf/udf
//  s        out  DSZ    current top of this stack (registered)
//  cnt      out  CW     live entries, 0..DEPTH
//  full     out  1      cnt==DEPTH (comb from cnt)
//  empty    out  1      cnt==0 (comb from cnt)
//  ovf      out  1      sticky overflow
//  udf      out  1      sticky underflow
// BEHAVIOUR
//  Reset (rst==0 at posedge): s=0, cnt=0, ovf=0, udf=0. Array contents
//   undefined, never read before written. Reset overrides any op that cycle.
//  Storage: mem[0..DEPTH-2]; wp = (cnt==0) ? 0 : cnt-1 = next free slot.
//   Async read, sync write.
//  Latency: op sampled at posedge N; s/cnt/flags valid after posedge N.
//   Back-to-back ops every cycle, no stalls, no handshake.
//  NOP: no change.
//  PUSH, cnt<DEPTH: if cnt>0, mem[wp]<=s. Then s<=vi, cnt<=cnt+1.
//   cnt==0: s<=vi only.
//  PUSH, cnt==DEPTH: ignored (s, cnt, mem unchanged), ovf<=1.
//  POP, cnt>=2: s<=mem[wp-1], cnt<=cnt-1.
//   cnt==1: s<=0, cnt<=0.
//   cnt==0: ignored, udf<=1.
//  PICK (push copy of element pidx): v = (pidx==0) ? s : mem[wp-pidx].
//   Legal when pidx<cnt and cnt<DEPTH; then behaves exactly as PUSH of v.
//   pidx>=cnt (incl. cnt==0): ignored, udf<=1.
//   pidx<cnt and cnt==DEPTH: ignored, ovf<=1.
//   Both checks failing: udf only.
//  v is read before the write in the same cycle (old-value semantics).
//  Sticky flags: clr_err=1 clears ovf/udf. A new error in the same cycle wins
//   (flag set). Errors never alter data state.
//  op is 2 bits; no illegal encodings.
//  Index arithmetic is unsigned in CW bits; legal ops never wrap.
// TESTING
//  1 reset; PUSH 0x11, 0x22, 0x33; POP x3
//    -> s=0x33, 0x22, 0x11, 0; cnt 3,2,1,0; empty=1; udf=0.
//  2 PUSH i for i=1..DEPTH -> full=1, s=DEPTH.
//    PUSH 0xDEAD -> ovf=1, s=DEPTH, cnt=DEPTH.
//    POP DEPTH times -> values DEPTH-1..1 then 0.
//  3 empty stack: POP -> udf=1, cnt=0, s=0.
//    clr_err=1 with POP in same cycle -> udf stays 1.
//    clr_err alone -> udf=0.
//  4 PUSH 0xA, 0xB, 0xC; PICK pidx=2 -> s=0xA, cnt=4.
//    PICK pidx=0 -> s=0xA, cnt=5.
//    PICK pidx=5 -> udf=1, cnt=5 unchanged.
//  5 PUSH 5 values; rst=0 concurrently with PUSH -> s=0, cnt=0, flags 0.
//    Release rst, PUSH 0x77 -> s=0x77, cnt=1.
//  6 random op stream (10k cycles) vs queue model
//    -> s, cnt, ovf, udf match every cycle.

Source files
------------

// File: rtl/ej32_dstack.sv
// eJ32 data-stack unit: cached top-of-stack register backed by a register-file
// array, servicing PUSH / POP / PICK in a single cycle with sticky error flags.

package ej32_dstack_pkg;
  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_PUSH = 2'b01,
    OP_PICK = 2'b10,
    OP_POP  = 2'b11
  } stack_op_e;
endpackage

module ej32_dstack
  import ej32_dstack_pkg::*;
#(
  parameter  int DEPTH = 64,
  parameter  int DSZ   = 32,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     op,
  input  logic [DSZ-1:0] vi,
  input  logic [CW-2:0]  pidx,
  input  logic           clr_err,
  output logic [DSZ-1:0] s,
  output logic [CW-1:0]  cnt,
  output logic           full,
  output logic           empty,
  output logic           ovf,
  output logic           udf
);

  // Array holds every entry below s, so it is one shorter than the stack.
  localparam int AW = (DEPTH - 1 > 1) ? $clog2(DEPTH - 1) : 1;

  logic [DSZ-1:0] mem [DEPTH-1];

  logic [DSZ-1:0] s_q, s_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ovf_q, ovf_d;
  logic           udf_q, udf_d;

  stack_op_e      op_e;
  logic [CW-1:0]  wp;
  logic [CW-1:0]  pidx_ext;
  logic [CW-1:0]  pick_idx;
  logic [CW-1:0]  pop_idx;
  logic [DSZ-1:0] pick_val;
  logic [DSZ-1:0] pop_val;
  logic           full_w;
  logic           empty_w;
  logic           push_en;
  logic [DSZ-1:0] push_val;
  logic           mem_we;

  assign op_e     = stack_op_e'(op);
  assign full_w   = (cnt_q == CW'(DEPTH));
  assign empty_w  = (cnt_q == '0);
  assign wp       = empty_w ? '0 : cnt_q - CW'(1);
  assign pidx_ext = {1'b0, pidx};
  assign pick_idx = wp - pidx_ext;
  assign pop_idx  = wp - CW'(1);

  // Async reads see the array before this cycle's write (old-value semantics).
  assign pick_val = (pidx_ext == '0) ? s_q : mem[pick_idx[AW-1:0]];
  assign pop_val  = mem[pop_idx[AW-1:0]];

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    s_d      = s_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q & ~clr_err;
    udf_d    = udf_q & ~clr_err;
    push_en  = 1'b0;
    push_val = vi;
    mem_we   = 1'b0;

    case (op_e)
      OP_PUSH: begin
        if (full_w) ovf_d = 1'b1;
        else        push_en = 1'b1;
      end
      OP_PICK: begin
        // Underflow is checked first so a doubly-illegal pick reports udf only.
        if (pidx_ext >= cnt_q) begin
          udf_d = 1'b1;
        end else if (full_w) begin
          ovf_d = 1'b1;
        end else begin
          push_en  = 1'b1;
          push_val = pick_val;
        end
      end
      OP_POP: begin
        if (empty_w) begin
          udf_d = 1'b1;
        end else if (cnt_q == CW'(1)) begin
          s_d   = '0;
          cnt_d = '0;
        end else begin
          s_d   = pop_val;
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: ;
    endcase

    if (push_en) begin
      mem_we = ~empty_w;
      s_d    = push_val;
      cnt_d  = cnt_q + CW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s_q   <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      s_q   <= s_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  // NOTE: the array is deliberately not reset; a slot is always written before
  // it is read, and leaving it out keeps it mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (rst && mem_we) mem[wp[AW-1:0]] <= s_q;
  end

  assign s     = s_q;
  assign cnt   = cnt_q;
  assign full  = full_w;
  assign empty = empty_w;
  assign ovf   = ovf_q;
  assign udf   = udf_q;

endmodule

// File: tb/tb_ej32_dstack.sv
// Self-checking bench for ej32_dstack: directed vector table, hand-written
// corner sequences, and a random op stream checked against a queue model.

module tb_ej32_dstack;

  localparam int DEPTH = 64;
  localparam int DSZ   = 32;
  localparam int CW    = $clog2(DEPTH + 1);

  localparam logic [1:0] NOP  = 2'b00;
  localparam logic [1:0] PUSH = 2'b01;
  localparam logic [1:0] PICK = 2'b10;
  localparam logic [1:0] POP  = 2'b11;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [1:0]     op;
  logic [DSZ-1:0] vi;
  logic [CW-2:0]  pidx;
  logic           clr_err;
  logic [DSZ-1:0] s;
  logic [CW-1:0]  cnt;
  logic           full, empty, ovf, udf;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the whole stack as a queue, back element is the top.
  logic [DSZ-1:0] mq[$];
  logic           m_ovf, m_udf;

  typedef struct {
    logic [1:0]     op;
    logic [DSZ-1:0] vi;
    logic [CW-2:0]  pidx;
    logic           clr;
    logic           rst_n;
    logic [DSZ-1:0] s;
    int             cnt;
    logic           ovf;
    logic           udf;
  } vec_t;

  vec_t vecs[$];

  ej32_dstack #(.DEPTH(DEPTH), .DSZ(DSZ)) dut (
    .clk(clk), .rst(rst_n), .op(op), .vi(vi), .pidx(pidx), .clr_err(clr_err),
    .s(s), .cnt(cnt), .full(full), .empty(empty), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DSZ-1:0] act, input logic [DSZ-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic [1:0] o, input logic [DSZ-1:0] v,
                              input int p, input logic clr, input logic r);
    int sz;
    sz = mq.size();
    if (!r) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      return;
    end
    if (clr) begin
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end
    case (o)
      PUSH: if (sz == DEPTH) m_ovf = 1'b1; else mq.push_back(v);
      POP:  if (sz == 0) m_udf = 1'b1; else void'(mq.pop_back());
      PICK: begin
        if (p >= sz)          m_udf = 1'b1;
        else if (sz == DEPTH) m_ovf = 1'b1;
        else                  mq.push_back(mq[sz-1-p]);
      end
      default: ;
    endcase
  endtask

  // Called at a negedge: drive, let the posedge sample, return at next negedge.
  task automatic step(input logic [1:0] o, input logic [DSZ-1:0] v,
                      input logic [CW-2:0] p, input logic clr, input logic r);
    op = o; vi = v; pidx = p; clr_err = clr; rst_n = r;
    @(posedge clk);
    model_update(o, v, int'(p), clr, r);
    @(negedge clk);
  endtask

  task automatic expect_state(input string tag, input logic [DSZ-1:0] es, input int ec,
                              input logic eo, input logic eu);
    check({tag, ".s"},     s,     es);
    check({tag, ".cnt"},   DSZ'(cnt), DSZ'(ec));
    check({tag, ".ovf"},   DSZ'(ovf), DSZ'(eo));
    check({tag, ".udf"},   DSZ'(udf), DSZ'(eu));
    check({tag, ".full"},  DSZ'(full),  DSZ'(ec == DEPTH));
    check({tag, ".empty"}, DSZ'(empty), DSZ'(ec == 0));
  endtask

  task automatic add(input logic [1:0] o, input logic [DSZ-1:0] v, input int p,
                     input logic clr, input logic r, input logic [DSZ-1:0] es,
                     input int ec, input logic eo, input logic eu);
    vec_t t;
    t.op = o; t.vi = v; t.pidx = (CW-1)'(p); t.clr = clr; t.rst_n = r;
    t.s = es; t.cnt = ec; t.ovf = eo; t.udf = eu;
    vecs.push_back(t);
  endtask

  initial begin
    int k;
    rst_n = 1'b0; op = NOP; vi = '0; pidx = '0; clr_err = 1'b0;
    m_ovf = 1'b0; m_udf = 1'b0;

    //   op    vi     pidx clr rst  s      cnt ovf udf
    add(NOP,  0,      0,   0,  0,   0,     0,  0,  0);
    add(PUSH, 'h11,   0,   0,  1,   'h11,  1,  0,  0);
    add(PUSH, 'h22,   0,   0,  1,   'h22,  2,  0,  0);
    add(PUSH, 'h33,   0,   0,  1,   'h33,  3,  0,  0);
    add(POP,  0,      0,   0,  1,   'h22,  2,  0,  0);
    add(POP,  0,      0,   0,  1,   'h11,  1,  0,  0);
    add(POP,  0,      0,   0,  1,   0,     0,  0,  0);
    add(POP,  0,      0,   0,  1,   0,     0,  0,  1);
    add(POP,  0,      0,   1,  1,   0,     0,  0,  1);
    add(NOP,  0,      0,   1,  1,   0,     0,  0,  0);
    add(PUSH, 'hA,    0,   0,  1,   'hA,   1,  0,  0);
    add(PUSH, 'hB,    0,   0,  1,   'hB,   2,  0,  0);
    add(PUSH, 'hC,    0,   0,  1,   'hC,   3,  0,  0);
    add(PICK, 0,      2,   0,  1,   'hA,   4,  0,  0);
    add(PICK, 0,      0,   0,  1,   'hA,   5,  0,  0);
    add(PICK, 0,      5,   0,  1,   'hA,   5,  0,  1);
    add(NOP,  0,      0,   1,  1,   'hA,   5,  0,  0);
    add(POP,  0,      0,   0,  1,   'hA,   4,  0,  0);
    add(POP,  0,      0,   0,  1,   'hC,   3,  0,  0);
    add(POP,  0,      0,   0,  1,   'hB,   2,  0,  0);
    add(PICK, 0,      1,   0,  1,   'hA,   3,  0,  0);
    add(PUSH, 'h5,    0,   0,  1,   'h5,   4,  0,  0);
    add(PUSH, 'h99,   0,   0,  0,   0,     0,  0,  0);
    add(PICK, 0,      0,   0,  1,   0,     0,  0,  1);
    add(PUSH, 'h77,   0,   1,  1,   'h77,  1,  0,  0);

    @(negedge clk);
    foreach (vecs[i]) begin
      step(vecs[i].op, vecs[i].vi, vecs[i].pidx, vecs[i].clr, vecs[i].rst_n);
      expect_state($sformatf("vec%0d", i), vecs[i].s, vecs[i].cnt, vecs[i].ovf, vecs[i].udf);
    end

    // Fill to capacity, then overflow by PUSH and by PICK.
    step(NOP, 0, 0, 0, 0);
    for (int i = 1; i <= DEPTH; i++) step(PUSH, DSZ'(i), 0, 0, 1);
    expect_state("fill", DSZ'(DEPTH), DEPTH, 0, 0);
    step(PUSH, 'hDEAD, 0, 0, 1);
    expect_state("push_full", DSZ'(DEPTH), DEPTH, 1, 0);
    step(PICK, 0, (CW-1)'(DEPTH-1), 1, 1);
    expect_state("pick_full", DSZ'(DEPTH), DEPTH, 1, 0);
    step(PICK, 0, (CW-1)'(DEPTH-1), 1, 1);
    expect_state("pick_full_clr", DSZ'(DEPTH), DEPTH, 1, 0);
    for (int i = 1; i <= DEPTH; i++) begin
      step(POP, 0, 0, 0, 1);
      expect_state($sformatf("drain%0d", i), DSZ'(DEPTH - i), DEPTH - i, 1, 0);
    end

    // Reset clears sticky flags and overrides a concurrent PUSH.
    for (int i = 1; i <= 5; i++) step(PUSH, DSZ'(i * 3), 0, 0, 1);
    step(PUSH, 'h1234, 0, 0, 0);
    expect_state("rst_over_push", 0, 0, 0, 0);

    // Deepest legal PICK: at cnt==DEPTH-1 fetch the bottom element.
    for (int i = 1; i < DEPTH; i++) step(PUSH, DSZ'(100 + i), 0, 0, 1);
    step(PICK, 0, (CW-1)'(DEPTH-2), 0, 1);
    expect_state("pick_deep", 101, DEPTH, 0, 0);
    step(NOP, 0, 0, 0, 0);

    // Random stream in phases biased towards filling and draining.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      int phase, r, sz;
      logic [1:0] o;
      logic [CW-2:0] p;
      phase = (cyc / 700) % 2;
      r = $urandom_range(0, 99);
      if (phase == 0) o = (r < 50) ? PUSH : (r < 70) ? PICK : (r < 90) ? POP : NOP;
      else            o = (r < 20) ? PUSH : (r < 35) ? PICK : (r < 90) ? POP : NOP;
      sz = mq.size();
      if ($urandom_range(0, 1) == 0 && sz > 0)
        p = (CW-1)'($urandom_range(0, (sz > DEPTH-1) ? DEPTH-1 : sz - 1));
      else
        p = (CW-1)'($urandom);
      step(o, $urandom, p, ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 999) != 0));
      k = mq.size();
      expect_state($sformatf("rnd%0d", cyc), (k > 0) ? mq[k-1] : '0, k, m_ovf, m_udf);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
